// File: rtl/opfb_fir_cfg_axis_stall_detector.sv
// Per-channel AXI-Stream stall monitor: counts consecutive stall cycles, flags
// channels stalled for THRESH cycles, and latches sticky/first-blocked status.
module opfb_fir_cfg_axis_stall_detector #(
    parameter int NUM_CH = 1,
    parameter int CNT_W  = 16,
    parameter int THRESH = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] tvalid,
    input  logic [NUM_CH-1:0] tready,
    input  logic [NUM_CH-1:0] rd_wait,
    input  logic              clear_sticky,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic [NUM_CH-1:0] stall_sticky,
    output logic [2:0]        first_ch,
    output logic              first_valid
);

    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE     = 1'b0,
        CAPTURED = 1'b1
    } state_t;

    logic [CNT_W-1:0]  cnt_r [NUM_CH];
    logic [NUM_CH-1:0] stall_s;
    logic [NUM_CH-1:0] xfer_s;
    logic [NUM_CH-1:0] over_s;
    logic [NUM_CH-1:0] rise_s;
    logic [NUM_CH-1:0] block_r;
    logic [NUM_CH-1:0] sticky_r;
    logic [2:0]        lowest_s;
    logic [2:0]        first_ch_r;
    logic [2:0]        first_ch_s;
    logic              first_valid_r;
    state_t            state_r;
    state_t            state_s;

    // Per-channel stall/transfer decode and threshold compare on the held count
    always_comb begin
        stall_s = (tvalid & ~tready) | (rd_wait & ~tvalid);
        xfer_s  = tvalid & tready;
        over_s  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            over_s[i] = (cnt_r[i] >= THR);
        end
        rise_s = over_s & ~block_r;
    end

    // Saturating stall counters; any clear condition beats the increment
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset || !enable || xfer_s[i] || !stall_s[i]) begin
                cnt_r[i] <= '0;
            end else if (cnt_r[i] != CNT_MAX) begin
                cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r[i] <= cnt_r[i];
            end
        end
    end

    // Blocked flags and sticky status; a new rise wins over a same-cycle clear
    always_ff @(posedge clock) begin
        if (reset) begin
            block_r  <= '0;
            sticky_r <= '0;
        end else begin
            block_r  <= over_s;
            sticky_r <= (clear_sticky ? {NUM_CH{1'b0}} : sticky_r) | rise_s;
        end
    end

    // Lowest-index channel among those rising this cycle
    always_comb begin
        lowest_s = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rise_s[i]) begin
                lowest_s = 3'(i);
            end else begin
                lowest_s = lowest_s;
            end
        end
    end

    // Capture FSM next state: first block after a clear is latched, later ones ignored
    always_comb begin
        state_s    = state_r;
        first_ch_s = first_ch_r;
        case (state_r)
            IDLE: begin
                if (|rise_s) begin
                    state_s    = CAPTURED;
                    first_ch_s = lowest_s;
                end else begin
                    state_s    = IDLE;
                    first_ch_s = 3'd0;
                end
            end
            CAPTURED: begin
                if (clear_sticky && (|rise_s)) begin
                    state_s    = CAPTURED;
                    first_ch_s = lowest_s;
                end else if (clear_sticky) begin
                    state_s    = IDLE;
                    first_ch_s = 3'd0;
                end else begin
                    state_s    = CAPTURED;
                    first_ch_s = first_ch_r;
                end
            end
            default: begin
                state_s    = IDLE;
                first_ch_s = 3'd0;
            end
        endcase
    end

    // Capture FSM state and its registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            first_ch_r    <= 3'd0;
            first_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            first_ch_r    <= first_ch_s;
            first_valid_r <= (state_s == CAPTURED);
        end
    end

    assign axis_block_sigs = block_r;
    assign stall_sticky    = sticky_r;
    assign first_ch        = first_ch_r;
    assign first_valid     = first_valid_r;

endmodule

// File: tb/tb_opfb_fir_cfg_axis_stall_detector.sv
// Randomized bench for the stall detector, checked every cycle against a
// run-length model of each channel's stall history.
module tb_opfb_fir_cfg_axis_stall_detector;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
    localparam int THRESH = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic [NUM_CH-1:0] tvalid;
    logic [NUM_CH-1:0] tready;
    logic [NUM_CH-1:0] rd_wait;
    logic              clear_sticky;
    logic [NUM_CH-1:0] axis_block_sigs;
    logic [NUM_CH-1:0] stall_sticky;
    logic [2:0]        first_ch;
    logic              first_valid;

    int checks = 0;
    int errors = 0;

    opfb_fir_cfg_axis_stall_detector #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .THRESH(THRESH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .tvalid         (tvalid),
        .tready         (tready),
        .rd_wait        (rd_wait),
        .clear_sticky   (clear_sticky),
        .axis_block_sigs(axis_block_sigs),
        .stall_sticky   (stall_sticky),
        .first_ch       (first_ch),
        .first_valid    (first_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: length of the current qualifying stall run per channel.
    // A channel is blocked after an edge iff its run before that edge was >= THRESH.
    int                run [NUM_CH];
    logic [NUM_CH-1:0] exp_block  = '0;
    logic [NUM_CH-1:0] exp_sticky = '0;
    logic              exp_fv     = 1'b0;
    logic [2:0]        exp_fc     = 3'd0;

    initial begin : model_and_compare
        logic [NUM_CH-1:0] nb;
        logic [NUM_CH-1:0] rise;
        bit                st;
        for (int i = 0; i < NUM_CH; i++) run[i] = 0;
        forever begin
            @(negedge clock);
            check("axis_block_sigs", 32'(axis_block_sigs), 32'(exp_block));
            check("stall_sticky",    32'(stall_sticky),    32'(exp_sticky));
            check("first_valid",     32'(first_valid),     32'(exp_fv));
            check("first_ch",        32'(first_ch),        32'(exp_fc));
            // advance the model to the state after the coming edge
            if (reset) begin
                for (int i = 0; i < NUM_CH; i++) run[i] = 0;
                exp_block  = '0;
                exp_sticky = '0;
                exp_fv     = 1'b0;
                exp_fc     = 3'd0;
            end else begin
                nb = '0;
                for (int i = 0; i < NUM_CH; i++) nb[i] = (run[i] >= THRESH);
                rise = nb & ~exp_block;
                for (int i = 0; i < NUM_CH; i++) begin
                    st = (tvalid[i] && !tready[i]) || (rd_wait[i] && !tvalid[i]);
                    run[i] = (enable && st) ? run[i] + 1 : 0;
                end
                exp_sticky = (clear_sticky ? '0 : exp_sticky) | rise;
                if (rise != '0 && (!exp_fv || clear_sticky)) begin
                    exp_fv = 1'b1;
                    for (int i = NUM_CH - 1; i >= 0; i--) if (rise[i]) exp_fc = 3'(i);
                end else if (clear_sticky) begin
                    exp_fv = 1'b0;
                    exp_fc = 3'd0;
                end
                exp_block = nb;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    int mode [NUM_CH];

    initial begin : driver
        reset = 1'b1; enable = 1'b1; clear_sticky = 1'b0;
        tvalid = '0; tready = '0; rd_wait = '0;
        cycles(2);
        // channel 2 starved from its first post-reset cycle
        reset = 1'b0; rd_wait = 4'b0100;
        cycles(5);
        check("lit_no_block_at_thresh", 32'(axis_block_sigs), 32'h0);
        tvalid[1] = 1'b1;
        cycles(1);
        check("lit_ch2_block", 32'(axis_block_sigs), 32'h4);
        check("lit_ch2_sticky", 32'(stall_sticky), 32'h4);
        check("lit_first_valid", 32'(first_valid), 32'h1);
        check("lit_first_ch2", 32'(first_ch), 32'h2);
        cycles(4);
        check("lit_ch1_not_yet", 32'(axis_block_sigs), 32'h4);
        cycles(1);
        check("lit_both_block", 32'(axis_block_sigs), 32'h6);
        check("lit_both_sticky", 32'(stall_sticky), 32'h6);
        check("lit_first_ch_kept", 32'(first_ch), 32'h2);
        clear_sticky = 1'b1;
        cycles(1);
        clear_sticky = 1'b0;
        check("lit_clear_sticky", 32'(stall_sticky), 32'h0);
        check("lit_clear_fv", 32'(first_valid), 32'h0);
        tready[1] = 1'b1;
        cycles(1);
        check("lit_xfer_flag_held", 32'(axis_block_sigs), 32'h6);
        tready[1] = 1'b0;
        cycles(1);
        check("lit_xfer_flag_drop", 32'(axis_block_sigs), 32'h4);
        cycles(4);
        clear_sticky = 1'b1;
        cycles(1);
        clear_sticky = 1'b0;
        check("lit_set_beats_clear", 32'(stall_sticky), 32'h2);
        check("lit_recapture_fc", 32'(first_ch), 32'h1);
        check("lit_recapture_fv", 32'(first_valid), 32'h1);
        enable = 1'b0;
        cycles(1);
        check("lit_disable_held", 32'(axis_block_sigs), 32'h6);
        cycles(1);
        check("lit_disable_drop", 32'(axis_block_sigs), 32'h0);
        check("lit_disable_sticky", 32'(stall_sticky), 32'h2);
        enable = 1'b1;
        cycles(3);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("lit_reset_sticky", 32'(stall_sticky), 32'h0);
        check("lit_reset_fv", 32'(first_valid), 32'h0);
        cycles(5);
        check("lit_reset_restart", 32'(axis_block_sigs), 32'h0);
        cycles(1);
        check("lit_reset_reblock", 32'(axis_block_sigs), 32'h6);
        check("lit_lowest_rising", 32'(first_ch), 32'h1);

        // randomized phase: per-channel behaviour persists in runs so stalls get long
        for (int i = 0; i < NUM_CH; i++) mode[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 15) == 0) mode[i] = int'($urandom_range(0, 4));
                case (mode[i])
                    0: begin tvalid[i] = 1'b1; tready[i] = 1'b0; rd_wait[i] = 1'($urandom); end
                    1: begin tvalid[i] = 1'b0; tready[i] = 1'($urandom); rd_wait[i] = 1'b1; end
                    2: begin tvalid[i] = 1'b1; tready[i] = 1'b1; rd_wait[i] = 1'($urandom); end
                    3: begin tvalid[i] = 1'b0; tready[i] = 1'($urandom); rd_wait[i] = 1'b0; end
                    default: begin
                        tvalid[i] = 1'($urandom); tready[i] = 1'($urandom); rd_wait[i] = 1'($urandom);
                    end
                endcase
            end
            enable       = ($urandom_range(0, 39) != 0);
            reset        = ($urandom_range(0, 199) == 0);
            clear_sticky = ($urandom_range(0, 24) == 0);
            cycles(1);
        end
        reset = 1'b0; clear_sticky = 1'b0;
        cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opfb_fir_cfg_axis_stall_detector.md
OPFB_FIR_CFG_AXIS_STALL_DETECTOR -- requirements
Module: opfb_fir_cfg_axis_stall_detector

Interface
REQ-001 Parameter NUM_CH, default 1: number of monitored AXI-Stream channels, range 1..8.
REQ-002 Parameter CNT_W, default 16: stall counter width, range 4..32.
REQ-003 Parameter THRESH, default 1024: stall cycles before a channel is declared blocked, range 1..2^CNT_W-1.
REQ-004 Port clock  input  1: sole clock, all logic on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high.
REQ-006 Port enable  input  1: 1 = monitoring active; 0 = counters cleared and held.
REQ-007 Port tvalid  input  NUM_CH: per-channel producer valid.
REQ-008 Port tready  input  NUM_CH: per-channel consumer ready.
REQ-009 Port rd_wait  input  NUM_CH: per-channel consumer waiting for data.
REQ-010 Port clear_sticky  input  1: single-cycle pulse clearing sticky status and first-block capture.
REQ-011 Port axis_block_sigs  output  NUM_CH: per-channel blocked flag, drives the deadlock monitor input of the same name.
REQ-012 Port stall_sticky  output  NUM_CH: per-channel latched "blocked at least once".
REQ-013 Port first_ch  output  3: index of first channel to block since last clear.
REQ-014 Port first_valid  output  1: first_ch holds a captured index.

Function
REQ-015 Channel i stall condition SHALL be (tvalid[i] & ~tready[i]) | (rd_wait[i] & ~tvalid[i]).
REQ-016 Channel i transfer SHALL be tvalid[i] & tready[i].
REQ-017 Per channel, a CNT_W-bit counter SHALL increment by 1 each cycle with enable=1 and stall condition true.
REQ-018 Counter SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-019 Counter SHALL clear to 0 on any cycle with transfer, with no stall condition, or with enable=0; clear has priority over increment.
REQ-020 axis_block_sigs[i] SHALL be registered, 1 the cycle after counter reaches THRESH, with 1 cycle latency from the counter value.
REQ-021 Continuous stall from cycle 0 SHALL assert axis_block_sigs[i] first at cycle THRESH+1 (count THRESH registered at edge THRESH, flag at edge THRESH+1).
REQ-022 axis_block_sigs[i] SHALL deassert one cycle after the counter clears.
REQ-023 stall_sticky[i] SHALL set on the cycle axis_block_sigs[i] rises and hold until clear_sticky or reset.
REQ-024 Capture state machine, states IDLE and CAPTURED: IDLE->CAPTURED when any axis_block_sigs bit rises; first_ch = lowest index among bits rising that cycle; first_valid = 1.
REQ-025 CAPTURED SHALL ignore later blocks; CAPTURED->IDLE only on clear_sticky or reset.
REQ-026 clear_sticky coinciding with a new rising block SHALL give set priority: sticky bit remains 1 and capture reloads with the new channel.
REQ-027 Unused first_ch upper bits (NUM_CH<8) SHALL read 0.
REQ-028 enable falling mid-stall SHALL clear counters next edge and drop axis_block_sigs one cycle later; sticky and capture state SHALL be retained.

Reset
REQ-029 Reset SHALL force all counters 0, axis_block_sigs 0, stall_sticky 0, first_ch 0, first_valid 0, state IDLE, on the next rising edge.
REQ-030 Reset asserted mid-stall SHALL discard accumulated count; counting restarts from 0 after reset release.

Verification
REQ-031 NUM_CH=1, THRESH=4: tvalid=1, tready=0 from cycle 0 -> axis_block_sigs=1 at cycle 5, stall_sticky=1, first_valid=1, first_ch=0.
REQ-032 THRESH=4: stall 3 cycles, one transfer, stall 3 cycles -> axis_block_sigs never asserts.
REQ-033 NUM_CH=4, THRESH=8: rd_wait[2]=1, tvalid[2]=0 from cycle 0, channel 1 backpressured from cycle 3 -> first_ch=2; stall_sticky=0110 after both block.
REQ-034 CNT_W=4, THRESH=15: stall 40 cycles -> counter holds 15, flag stays 1, no wrap; transfer -> flag 0 two cycles later.
REQ-035 Channel blocked, clear_sticky pulsed while still blocked -> stall_sticky=0, first_valid=0; simultaneous clear and new rising channel -> that channel captured.
REQ-036 Reset pulsed at stall count 3 -> all outputs 0; stall resumed -> flag after THRESH+1 further cycles.
